l2_req_arbiter: RTL and testbench

L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

---
 rtl/l2_req_arbiter_pkg.sv | 18 +
 rtl/l2_req_arbiter_if.sv | 43 ++++
 rtl/l2_req_arbiter_rr_arbiter2.sv | 33 +++
 rtl/l2_req_arbiter.sv | 102 ++++++++++
 tb/tb_l2_req_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/l2_req_arbiter_pkg.sv
// Shared types and default widths for the L1-to-L2 request arbiter.
package l2_arb_pkg;
   localparam int DEF_ADDR_W  = 64;
   localparam int DEF_WDATA_W = 64;
   localparam int DEF_LINE_W  = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;
endpackage

// File: rtl/l2_req_arbiter_if.sv
// Bundle of requester (L1_I / L1_D) and L2-side signals around the arbiter.
// master: the arbiter itself; slave: the surrounding caches / L2 model.
interface l2_req_arbiter_if
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int WDATA_W = DEF_WDATA_W,
   parameter int LINE_W  = DEF_LINE_W
) ();
   logic               i_req,   d_req;
   logic               i_we,    d_we;
   logic [ADDR_W-1:0]  i_addr,  d_addr;
   logic [WDATA_W-1:0] i_wdata, d_wdata;
   logic [2:0]         i_size,  d_size;
   logic               i_clf,   d_clf;
   logic               i_done,  d_done;
   logic [LINE_W-1:0]  rdata;

   logic               l2_enable;
   logic               l2_we;
   logic [ADDR_W-1:0]  l2_addr;
   logic [WDATA_W-1:0] l2_wdata;
   logic [2:0]         l2_size;
   logic               l2_clf;
   logic               l2_done;
   logic [LINE_W-1:0]  l2_rdata;

   modport master (
      input  i_req, i_we, i_addr, i_wdata, i_size, i_clf,
      input  d_req, d_we, d_addr, d_wdata, d_size, d_clf,
      output i_done, d_done, rdata,
      output l2_enable, l2_we, l2_addr, l2_wdata, l2_size, l2_clf,
      input  l2_done, l2_rdata
   );

   modport slave (
      output i_req, i_we, i_addr, i_wdata, i_size, i_clf,
      output d_req, d_we, d_addr, d_wdata, d_size, d_clf,
      input  i_done, d_done, rdata,
      input  l2_enable, l2_we, l2_addr, l2_wdata, l2_size, l2_clf,
      output l2_done, l2_rdata
   );
endinterface

// File: rtl/l2_req_arbiter_rr_arbiter2.sv
// Two-way picker with a last-served pointer. Define L2_ARB_FIXED_PRIO_EN
// to make ties always go to D instead of alternating.
module rr_arbiter2
   import l2_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   req_i,
   input  logic   req_d,
   input  logic   upd,
   output owner_t grant
);
   owner_t last;
   owner_t tie_pick;

`ifdef L2_ARB_FIXED_PRIO_EN
   assign tie_pick = OWN_D;
`else
   assign tie_pick = (last == OWN_D) ? OWN_I : OWN_D;
`endif

   always_comb begin
      grant = OWN_I;
      if (req_i && req_d) grant = tie_pick;
      else if (req_d)     grant = OWN_D;
   end

   // Reset to D so the very first tie goes to I.
   always_ff @(posedge clk) begin
      if (rst)      last <= OWN_D;
      else if (upd) last <= grant;
   end
endmodule

// File: rtl/l2_req_arbiter.sv
// Serialises L1_I / L1_D misses onto a single-outstanding L2 port.
// Tie policy selectable with L2_ARB_FIXED_PRIO_EN (see rr_arbiter2).
module l2_req_arbiter
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int WDATA_W = DEF_WDATA_W,
   parameter int LINE_W  = DEF_LINE_W
) (
   input logic             clk,
   input logic             rst,
   l2_req_arbiter_if.master bus
);
   state_t             state;
   owner_t             owner;
   owner_t             pick;
   logic               grant_upd;
   logic               en_q, we_q, clf_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WDATA_W-1:0] wdata_q;
   logic [2:0]         size_q;
   logic               i_done_q, d_done_q;
   logic [LINE_W-1:0]  rdata_q;

   assign grant_upd = (state == ST_IDLE) && (bus.i_req || bus.d_req);

   rr_arbiter2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .req_i (bus.i_req),
      .req_d (bus.d_req),
      .upd   (grant_upd),
      .grant (pick)
   );

   // l2_* registers double as the latched request fields; they are cleared
   // on the way into RESP so they read 0 in RESP and IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         owner    <= OWN_I;
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         clf_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= '0;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         en_q     <= 1'b0;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         rdata_q  <= '0;
         case (state)
            ST_IDLE: if (grant_upd) begin
               owner <= pick;
               state <= ST_ISSUE;
               en_q  <= 1'b1;
               if (pick == OWN_D) begin
                  we_q    <= bus.d_we;
                  addr_q  <= bus.d_addr;
                  wdata_q <= bus.d_wdata;
                  size_q  <= bus.d_size;
                  clf_q   <= bus.d_clf;
               end else begin
                  we_q    <= bus.i_we;
                  addr_q  <= bus.i_addr;
                  wdata_q <= bus.i_wdata;
                  size_q  <= bus.i_size;
                  clf_q   <= bus.i_clf;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: if (bus.l2_done) begin
               state    <= ST_RESP;
               rdata_q  <= bus.l2_rdata;
               i_done_q <= (owner == OWN_I);
               d_done_q <= (owner == OWN_D);
               we_q     <= 1'b0;
               clf_q    <= 1'b0;
               addr_q   <= '0;
               wdata_q  <= '0;
               size_q   <= '0;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.l2_enable = en_q;
   assign bus.l2_we     = we_q;
   assign bus.l2_addr   = addr_q;
   assign bus.l2_wdata  = wdata_q;
   assign bus.l2_size   = size_q;
   assign bus.l2_clf    = clf_q;
   assign bus.i_done    = i_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed cycle-accurate bench for l2_req_arbiter.
module tb_l2_req_arbiter;
   import l2_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   l2_req_arbiter_if bus ();

   l2_req_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs();
      bus.i_req = 0; bus.i_we = 0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_size = '0; bus.i_clf = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_size = '0; bus.d_clf = 0;
      bus.l2_done = 0; bus.l2_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1; step(); step(); rst = 0;
   endtask

   // Leaves the bench in the cycle where the arbiter is in RESP.
   task automatic pulse_done(input logic [127:0] line);
      bus.l2_done = 1; bus.l2_rdata = line; step(); bus.l2_done = 0;
   endtask

   function automatic owner_t exp_tie(input owner_t last);
`ifdef L2_ARB_FIXED_PRIO_EN
      return OWN_D;
`else
      return (last == OWN_D) ? OWN_I : OWN_D;
`endif
   endfunction

   task automatic test_reset();
      clear_inputs();
      bus.d_req = 1; bus.d_addr = 64'd4096;
      rst = 1; step(); step();
      checks++; if (bus.l2_enable !== 1'b0) begin errors++; $display("FAIL reset_en got=%0d exp=0", bus.l2_enable); end
      checks++; if (bus.l2_addr !== 64'd0) begin errors++; $display("FAIL reset_addr got=%0h exp=0", bus.l2_addr); end
      checks++; if ({bus.i_done, bus.d_done} !== 2'b00) begin errors++; $display("FAIL reset_done got=%b exp=00", {bus.i_done, bus.d_done}); end
      checks++; if (bus.rdata !== 128'd0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", bus.rdata); end
      checks++; if ({bus.l2_we, bus.l2_clf, bus.l2_size} !== 5'd0) begin errors++; $display("FAIL reset_fields got=%b exp=0", {bus.l2_we, bus.l2_clf, bus.l2_size}); end
      bus.d_req = 0; rst = 0;
   endtask

   task automatic test_single_d();
      clear_inputs(); do_reset();
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'd4096; bus.d_wdata = 64'd8; bus.d_size = 3'd3;
      step();
      checks++; if (bus.l2_enable !== 1'b1) begin errors++; $display("FAIL single_en got=%0d exp=1", bus.l2_enable); end
      checks++; if (bus.l2_addr !== 64'd4096) begin errors++; $display("FAIL single_addr got=%0d exp=4096", bus.l2_addr); end
      checks++; if (bus.l2_wdata !== 64'd8) begin errors++; $display("FAIL single_wdata got=%0d exp=8", bus.l2_wdata); end
      checks++; if ({bus.l2_we, bus.l2_size} !== 4'b1011) begin errors++; $display("FAIL single_we_size got=%b exp=1011", {bus.l2_we, bus.l2_size}); end
      step();
      checks++; if (bus.l2_enable !== 1'b0) begin errors++; $display("FAIL single_en_drop got=%0d exp=0", bus.l2_enable); end
      step();
      pulse_done(128'h0);
      checks++; if ({bus.i_done, bus.d_done} !== 2'b01) begin errors++; $display("FAIL single_done got=%b exp=01", {bus.i_done, bus.d_done}); end
      checks++; if (bus.l2_addr !== 64'd0) begin errors++; $display("FAIL single_resp_addr got=%0d exp=0", bus.l2_addr); end
      bus.d_req = 0;
      step();
      checks++; if ({bus.i_done, bus.d_done} !== 2'b00) begin errors++; $display("FAIL single_done_clr got=%b exp=00", {bus.i_done, bus.d_done}); end
   endtask

   task automatic test_tie_after_reset();
      owner_t first;
      clear_inputs(); do_reset();
      first = exp_tie(OWN_D);
      bus.i_req = 1; bus.i_addr = 64'd100; bus.d_req = 1; bus.d_addr = 64'd200;
      step();
      checks++; if (bus.l2_enable !== 1'b1 || bus.l2_addr !== ((first == OWN_I) ? 64'd100 : 64'd200))
         begin errors++; $display("FAIL tie_first got_en=%0d got_addr=%0d exp_owner=%0d", bus.l2_enable, bus.l2_addr, first); end
      step(); pulse_done(128'h0);
      checks++; if (bus.d_done !== (first == OWN_D) || bus.i_done !== (first == OWN_I))
         begin errors++; $display("FAIL tie_first_done got=%b exp_owner=%0d", {bus.i_done, bus.d_done}, first); end
      if (first == OWN_I) bus.i_req = 0; else bus.d_req = 0;
      step();
      checks++; if (bus.l2_enable !== 1'b0) begin errors++; $display("FAIL tie_idle_en got=%0d exp=0", bus.l2_enable); end
      step();
      checks++; if (bus.l2_enable !== 1'b1 || bus.l2_addr !== ((first == OWN_I) ? 64'd200 : 64'd100))
         begin errors++; $display("FAIL tie_second got_en=%0d got_addr=%0d", bus.l2_enable, bus.l2_addr); end
      step(); pulse_done(128'h0);
      checks++; if (bus.d_done !== (first == OWN_I) || bus.i_done !== (first == OWN_D))
         begin errors++; $display("FAIL tie_second_done got=%b", {bus.i_done, bus.d_done}); end
      bus.i_req = 0; bus.d_req = 0; step();
   endtask

   task automatic test_alternate();
      owner_t last = OWN_D;
      owner_t expo;
      clear_inputs(); do_reset();
      bus.i_req = 1; bus.i_addr = 64'd100; bus.d_req = 1; bus.d_addr = 64'd200;
      for (int n = 0; n < 4; n++) begin
         expo = exp_tie(last); last = expo;
         step();
         checks++; if (bus.l2_enable !== 1'b1 || bus.l2_addr !== ((expo == OWN_I) ? 64'd100 : 64'd200))
            begin errors++; $display("FAIL alt_grant%0d got_addr=%0d exp_owner=%0d", n, bus.l2_addr, expo); end
         step(); pulse_done(128'h0);
         checks++; if ({bus.i_done, bus.d_done} !== ((expo == OWN_I) ? 2'b10 : 2'b01))
            begin errors++; $display("FAIL alt_done%0d got=%b exp_owner=%0d", n, {bus.i_done, bus.d_done}, expo); end
         step();
      end
      bus.i_req = 0; bus.d_req = 0; step();
   endtask

   task automatic test_addr_change_rdata();
      clear_inputs(); do_reset();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'd4096;
      step(); step();
      bus.d_addr = 64'd8192; bus.d_wdata = 64'hFF; bus.d_we = 1;
      step();
      checks++; if (bus.l2_addr !== 64'd4096) begin errors++; $display("FAIL hold_addr got=%0d exp=4096", bus.l2_addr); end
      checks++; if (bus.l2_we !== 1'b0 || bus.l2_wdata !== 64'd0) begin errors++; $display("FAIL hold_we_wdata got=%0d/%0h exp=0/0", bus.l2_we, bus.l2_wdata); end
      pulse_done(128'hA5);
      checks++; if (bus.rdata !== 128'hA5) begin errors++; $display("FAIL rdata_done got=%0h exp=a5", bus.rdata); end
      checks++; if (bus.d_done !== 1'b1) begin errors++; $display("FAIL rdata_dn got=%0d exp=1", bus.d_done); end
      bus.d_req = 0;
      step();
      checks++; if (bus.rdata !== 128'd0) begin errors++; $display("FAIL rdata_after got=%0h exp=0", bus.rdata); end
   endtask

   task automatic test_stray_and_reset();
      clear_inputs(); do_reset();
      pulse_done(128'h77);
      checks++; if ({bus.i_done, bus.d_done, bus.l2_enable} !== 3'b000) begin errors++; $display("FAIL stray_idle got=%b exp=000", {bus.i_done, bus.d_done, bus.l2_enable}); end
      step();
      checks++; if ({bus.i_done, bus.d_done} !== 2'b00 || bus.rdata !== 128'd0) begin errors++; $display("FAIL stray_idle2 got=%b/%0h", {bus.i_done, bus.d_done}, bus.rdata); end
      bus.i_req = 1; bus.i_addr = 64'd300;
      step(); step();
      rst = 1; bus.i_req = 0; step(); rst = 0;
      checks++; if (bus.l2_addr !== 64'd0 || bus.l2_enable !== 1'b0) begin errors++; $display("FAIL midrst_out got_addr=%0d got_en=%0d exp=0", bus.l2_addr, bus.l2_enable); end
      pulse_done(128'h55);
      checks++; if ({bus.i_done, bus.d_done} !== 2'b00) begin errors++; $display("FAIL midrst_nodone got=%b exp=00", {bus.i_done, bus.d_done}); end
      bus.i_req = 1; bus.i_addr = 64'd400;
      step();
      checks++; if (bus.l2_enable !== 1'b1 || bus.l2_addr !== 64'd400) begin errors++; $display("FAIL postrst_issue got_en=%0d got_addr=%0d exp=1/400", bus.l2_enable, bus.l2_addr); end
      step(); pulse_done(128'h1);
      checks++; if ({bus.i_done, bus.d_done} !== 2'b10) begin errors++; $display("FAIL postrst_done got=%b exp=10", {bus.i_done, bus.d_done}); end
      bus.i_req = 0; step();
   endtask

   initial begin
      test_reset();
      test_single_d();
      test_tie_after_reset();
      test_alternate();
      test_addr_change_rdata();
      test_stray_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
